// File: rtl/owts_beat_sequencer.sv
// Beat sequencer for the melody player: steps a beat index every TICKS_PER_BEAT clocks,
// with start/stop/pause control and optional looping after LAST_BEAT.
module owts_beat_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 32'd12500000,
  parameter int unsigned LAST_BEAT      = 32'd67
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  output logic [7:0] beats,
  output logic       playing,
  output logic       beat_strobe,
  output logic       done
);

  localparam logic [31:0] TickLast = 32'(TICKS_PER_BEAT - 32'd1);
  localparam logic [7:0]  BeatLast = 8'(LAST_BEAT);

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StPause
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] tick_q, tick_d;
  logic [7:0]  beats_q, beats_d;
  logic        playing_q, playing_d;
  logic        strobe_q, strobe_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    beats_d  = beats_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;

    if (stop) begin
      state_d = StIdle;
      tick_d  = '0;
      beats_d = '0;
    end else if (start) begin
      state_d  = StPlay;
      tick_d   = '0;
      beats_d  = '0;
      strobe_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tick_d  = '0;
          beats_d = '0;
        end
        StPlay, StPause: begin
          if (pause) begin
            state_d = StPause;
          end else begin
            // Leaving pause counts this cycle too, so a pause adds exactly its own length.
            state_d = StPlay;
            if (tick_q < TickLast) begin
              tick_d = tick_q + 32'd1;
            end else begin
              tick_d = '0;
              if (beats_q < BeatLast) begin
                beats_d  = beats_q + 8'd1;
                strobe_d = 1'b1;
              end else if (loop_en) begin
                beats_d  = '0;
                strobe_d = 1'b1;
              end else begin
                state_d = StIdle;
                beats_d = '0;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = StIdle;
          tick_d  = '0;
          beats_d = '0;
        end
      endcase
    end

    playing_d = (state_d != StIdle);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      beats_q   <= '0;
      playing_q <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      beats_q   <= beats_d;
      playing_q <= playing_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
    end
  end

  assign beats       = beats_q;
  assign playing     = playing_q;
  assign beat_strobe = strobe_q;
  assign done        = done_q;

endmodule

// File: doc/owts_beat_sequencer.md
OWTS_BEAT_SEQUENCER -- requirements
Module: owts_beat_sequencer

Interface
REQ-001 Parameter TICKS_PER_BEAT, default 12500000: CLOCK_50 cycles per beat (0.25 s); legal range 2..2^32-1.
REQ-002 Parameter LAST_BEAT, default 67: final beat index of the song; legal range 1..255.
REQ-003 CLOCK_50  input  1  the single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  synchronous; starts playback from beat 0, or restarts it if already playing.
REQ-006 stop  input  1  synchronous; aborts playback and returns to idle.
REQ-007 pause  input  1  synchronous, level-sensitive; freezes playback while high.
REQ-008 loop_en  input  1  synchronous, level-sensitive; 1 = wrap to beat 0 after LAST_BEAT, 0 = end after LAST_BEAT.
REQ-009 beats  output  8  registered beat index; drives the beats input of owts_melody_player.
REQ-010 playing  output  1  registered; high in states PLAY and PAUSE.
REQ-011 beat_strobe  output  1  registered one-cycle pulse each time a new beat index takes effect, including beat 0 at start and at a loop wrap.
REQ-012 done  output  1  registered one-cycle pulse when a non-looping song ends.

Function
REQ-013 States SHALL be IDLE, PLAY and PAUSE, encoded in one state register.
REQ-014 A tick counter of 32 bits SHALL count CLOCK_50 cycles within the current beat.
REQ-015 Input priority within a cycle SHALL be, highest first: stop, start, pause.
REQ-016 stop in any state SHALL take effect on the next edge: state IDLE, beats=0, tick=0, playing=0, no beat_strobe, no done.
REQ-017 start (stop low) in IDLE, PLAY or PAUSE SHALL take effect on the next edge: state PLAY, beats=0, tick=0, playing=1, beat_strobe=1 for that one cycle.
REQ-018 IDLE with no start SHALL hold beats=0 and tick=0.
REQ-019 PLAY, no start or stop, pause high: next state PAUSE; tick and beats hold their values.
REQ-020 PAUSE: tick and beats hold while pause is high; when pause is low, next state is PLAY and counting resumes from the held tick value.
REQ-021 PLAY, no start/stop/pause, tick < TICKS_PER_BEAT-1: tick increments by 1.
REQ-022 PLAY, no start/stop/pause, tick = TICKS_PER_BEAT-1, beats < LAST_BEAT: tick=0, beats=beats+1, beat_strobe=1.
REQ-023 Same condition with beats = LAST_BEAT and loop_en=1: tick=0, beats=0, beat_strobe=1, state stays PLAY.
REQ-024 Same condition with beats = LAST_BEAT and loop_en=0: state IDLE, beats=0, tick=0, playing=0, done=1 for one cycle, beat_strobe=0.
REQ-025 loop_en SHALL be sampled only at the beat boundary in REQ-023/REQ-024.
REQ-026 Each beat index from 1 to LAST_BEAT SHALL be held for exactly TICKS_PER_BEAT cycles when there is no pause; beat 0 after start is also held for TICKS_PER_BEAT cycles.
REQ-027 beat_strobe and done SHALL never be high in the same cycle.
REQ-028 beats SHALL never exceed LAST_BEAT.
REQ-029 Outputs SHALL be registered with no combinational path from inputs to outputs.

Reset
REQ-030 While reset is high: state IDLE, tick=0, beats=0, playing=0, beat_strobe=0, done=0, applied without waiting for a clock edge.
REQ-031 Reset asserted mid-playback or mid-pause SHALL abort immediately; after reset deasserts, the block waits in IDLE for start.
REQ-032 Reset deassertion SHALL be synchronous to CLOCK_50 at the system level; the block does not need an internal reset synchronizer.

Verification (TICKS_PER_BEAT=4, LAST_BEAT=3 unless stated)
REQ-033 Start pulse in IDLE, loop_en=0 -> beats sequence 0,1,2,3, each held 4 cycles, beat_strobe at each change; then done=1 for one cycle, beats=0, playing=0; 16 cycles from start edge to done.
REQ-034 loop_en=1 with the same start -> after beat 3, beats wraps to 0 with beat_strobe=1, no done, playing stays 1; the sequence repeats indefinitely.
REQ-035 pause high for 5 cycles during beat 2, tick=1 -> beats=2 frozen, playing=1, no strobes; after release, beat 2 lasts 3 more cycles, so 9 cycles total in beat 2.
REQ-036 start and stop high together during beat 2 -> stop wins: IDLE, beats=0, no done, no strobe; start alone during beat 2 -> beats=0, beat_strobe=1, tick=0.
REQ-037 Asynchronous reset pulse between clock edges during beat 1 -> all outputs 0 before the next edge; start after release replays from beat 0.
REQ-038 Defaults (12500000, 67) -> done occurs 68*12500000 cycles after start; beats stays ≤ 67 throughout.
